// File: rtl/vin_freq_pkg.sv
// Shared types and widths for the multi-channel period scheduler.
package vin_freq_pkg;

    localparam int unsigned RES_W = 32;
    localparam int unsigned CH_W  = 4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SELECT,
        S_ARM,
        S_MEASURE,
        S_STORE
    } state_t;

endpackage

// File: rtl/vin_edge_sync.sv
// Two-flop synchronizer plus history flop; one-cycle pulse on a synced rising edge.
module vin_edge_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic rise_c
);

    logic [1:0] sync_q;
    logic       hist_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= 2'b00;
            hist_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], din};
            hist_q <= sync_q[1];
        end
    end

    assign rise_c = sync_q[1] & ~hist_q;

endmodule

// File: rtl/vin_freq_scheduler.sv
// Round-robin period meter: one shared counter and FSM measure each enabled
// channel's period in clk cycles and publish it into a per-channel result slice.
module vin_freq_scheduler
    import vin_freq_pkg::*;
#(
    parameter int unsigned NUM_CH    = 4,
    parameter int unsigned RESET_CNT = 25000000,
    parameter int unsigned SETTLE    = 3
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_CH-1:0]       SIGNAL,
    input  logic [NUM_CH-1:0]       enable_mask,
    output logic [RES_W*NUM_CH-1:0] frequency,
    output logic [NUM_CH-1:0]       update,
    output logic                    busy,
    output logic [CH_W-1:0]         cur_ch
);

    localparam logic [RES_W-1:0] TIMEOUT_LAST = RES_W'(RESET_CNT - 1);
    localparam logic [RES_W-1:0] SETTLE_LAST  = RES_W'(SETTLE - 1);

    state_t            state_q, state_d;
    logic [RES_W-1:0]  cnt_q, cnt_d;
    logic [CH_W-1:0]   cur_ch_q, cur_ch_d;
    logic [RES_W-1:0]  freq_q [NUM_CH];
    logic [NUM_CH-1:0] rise_c;
    logic              cur_rise_c, cur_en_c, any_en_c, store_c;
    logic [CH_W-1:0]   adv_ch_c, first_ch_c;
    logic [RES_W-1:0]  result_c;

    // Next enabled index strictly above cur, else the lowest enabled index (may be cur itself).
    function automatic logic [CH_W-1:0] next_enabled(input logic [NUM_CH-1:0] mask,
                                                     input logic [CH_W-1:0]   cur);
        logic [CH_W-1:0] hi, lo;
        logic            found_hi;
        hi       = '0;
        lo       = '0;
        found_hi = 1'b0;
        for (int j = int'(NUM_CH) - 1; j >= 0; j--) begin
            if (mask[j]) begin
                lo = CH_W'(j);
                if (CH_W'(j) > cur) begin
                    hi       = CH_W'(j);
                    found_hi = 1'b1;
                end
            end
        end
        return found_hi ? hi : lo;
    endfunction

    for (genvar g = 0; g < int'(NUM_CH); g++) begin : g_sync
        vin_edge_sync u_sync (
            .clk    (clk),
            .rst_n  (rst_n),
            .din    (SIGNAL[g]),
            .rise_c (rise_c[g])
        );
        assign frequency[g*RES_W +: RES_W] = freq_q[g];
    end

    // Per-channel views of the channel that currently owns the counter.
    always_comb begin
        cur_rise_c = 1'b0;
        cur_en_c   = 1'b0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (cur_ch_q == CH_W'(i)) begin
                cur_rise_c = rise_c[i];
                cur_en_c   = enable_mask[i];
            end
        end
    end

    assign any_en_c   = |enable_mask;
    assign adv_ch_c   = next_enabled(enable_mask, cur_ch_q);
    assign first_ch_c = next_enabled(enable_mask, {CH_W{1'b1}});

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        cur_ch_d = cur_ch_q;
        store_c  = 1'b0;
        result_c = '0;
        case (state_q)
            S_IDLE: begin
                if (any_en_c) begin
                    cur_ch_d = first_ch_c;
                    cnt_d    = '0;
                    state_d  = S_SELECT;
                end
            end
            S_SELECT: begin
                if (!cur_en_c) begin
                    cnt_d    = '0;
                    cur_ch_d = any_en_c ? adv_ch_c : cur_ch_q;
                    state_d  = any_en_c ? S_SELECT : S_IDLE;
                end else if (cnt_q == SETTLE_LAST) begin
                    cnt_d   = '0;
                    state_d = S_ARM;
                end else begin
                    cnt_d = cnt_q + RES_W'(1);
                end
            end
            S_ARM: begin
                if (!cur_en_c) begin
                    cnt_d    = '0;
                    cur_ch_d = any_en_c ? adv_ch_c : cur_ch_q;
                    state_d  = any_en_c ? S_SELECT : S_IDLE;
                end else if (cur_rise_c) begin
                    cnt_d   = '0;
                    state_d = S_MEASURE;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    store_c = 1'b1;
                    state_d = S_STORE;
                end else begin
                    cnt_d = cnt_q + RES_W'(1);
                end
            end
            S_MEASURE: begin
                if (!cur_en_c) begin
                    cnt_d    = '0;
                    cur_ch_d = any_en_c ? adv_ch_c : cur_ch_q;
                    state_d  = any_en_c ? S_SELECT : S_IDLE;
                end else if (cur_rise_c) begin
                    store_c  = 1'b1;
                    result_c = cnt_q + RES_W'(1);
                    state_d  = S_STORE;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    store_c = 1'b1;
                    state_d = S_STORE;
                end else begin
                    cnt_d = cnt_q + RES_W'(1);
                end
            end
            S_STORE: begin
                cnt_d    = '0;
                cur_ch_d = any_en_c ? adv_ch_c : cur_ch_q;
                state_d  = any_en_c ? S_SELECT : S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Result and update are written on entry to STORE so they line up with the STORE cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            cur_ch_q <= '0;
            busy     <= 1'b0;
            update   <= '0;
            for (int i = 0; i < int'(NUM_CH); i++) freq_q[i] <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            cur_ch_q <= cur_ch_d;
            busy     <= (state_d != S_IDLE);
            for (int i = 0; i < int'(NUM_CH); i++) begin
                update[i] <= store_c && (cur_ch_q == CH_W'(i));
                if (store_c && (cur_ch_q == CH_W'(i))) freq_q[i] <= result_c;
            end
        end
    end

    assign cur_ch = cur_ch_q;

endmodule

// File: tb/tb_vin_freq_scheduler.sv
// Directed bench for vin_freq_scheduler with NUM_CH=4, RESET_CNT=1000, SETTLE=3.
module tb_vin_freq_scheduler;
    import vin_freq_pkg::*;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [3:0]   SIGNAL = 4'b0000;
    logic [3:0]   enable_mask = 4'b0000;
    logic [127:0] frequency;
    logic [3:0]   update;
    logic         busy;
    logic [3:0]   cur_ch;

    int checks = 0;
    int errors = 0;
    int per  [4];
    int gcnt [4];

    vin_freq_scheduler #(.NUM_CH(4), .RESET_CNT(1000), .SETTLE(3)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .SIGNAL      (SIGNAL),
        .enable_mask (enable_mask),
        .frequency   (frequency),
        .update      (update),
        .busy        (busy),
        .cur_ch      (cur_ch)
    );

    always #5 clk = ~clk;

    // Square-wave sources: period per[ch] clk cycles, high for the first half; 0 = held low.
    initial begin
        for (int c = 0; c < 4; c++) begin per[c] = 0; gcnt[c] = 0; end
        forever begin
            @(negedge clk);
            for (int c = 0; c < 4; c++) begin
                if (per[c] == 0) begin
                    SIGNAL[c] = 1'b0;
                    gcnt[c]   = 0;
                end else begin
                    if (gcnt[c] >= per[c]) gcnt[c] = 0;
                    SIGNAL[c] = (gcnt[c] < per[c] / 2);
                    gcnt[c]   = gcnt[c] + 1;
                end
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] slice(input int ch);
        return frequency[ch*32 +: 32];
    endfunction

    task automatic wait_update(input string tag, input int budget, output int cycles);
        cycles = 0;
        while (cycles < budget) begin
            @(posedge clk); #1;
            cycles++;
            if (update != 4'b0000) return;
        end
        checks++;
        errors++;
        $error("FAIL %s timeout observed=no_update expected=update_within_%0d", tag, budget);
    endtask

    task automatic wait_measure(input string tag, input logic [3:0] ch);
        for (int n = 0; n < 2000; n++) begin
            @(posedge clk); #1;
            if (dut.state_q == S_MEASURE && cur_ch == ch) return;
        end
        checks++;
        errors++;
        $error("FAIL %s timeout observed=no_measure expected=measure_on_ch%0d", tag, ch);
    endtask

    task automatic do_reset(input logic [3:0] mask);
        @(negedge clk);
        rst_n       = 1'b0;
        enable_mask = mask;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int cyc;

        // Reset values, checked before the first clock edge.
        #1;
        check("rst_freq", 32'(frequency != 128'd0), 32'd0);
        check("rst_update", 32'(update), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_cur_ch", 32'(cur_ch), 32'd0);

        // Empty mask stays idle, then a lone high channel is picked up next cycle.
        do_reset(4'b0000);
        for (int n = 0; n < 20; n++) begin
            @(posedge clk); #1;
            check("idle_busy", 32'(busy), 32'd0);
            check("idle_update", 32'(update), 32'd0);
        end
        @(negedge clk);
        enable_mask = 4'b1000;
        @(posedge clk); #1;
        check("pick_cur_ch", 32'(cur_ch), 32'd3);
        check("pick_busy", 32'(busy), 32'd1);

        // Single channel, 100-cycle period: store every second edge.
        do_reset(4'b0001);
        per[0] = 100;
        wait_update("single_first", 1000, cyc);
        check("single_upd", 32'(update), 32'b0001);
        check("single_val", slice(0), 32'd100);
        check("single_others", 32'(frequency[127:32] != 96'd0), 32'd0);
        wait_update("single_second", 1000, cyc);
        check("single_interval", 32'(cyc), 32'd200);
        check("single_val2", slice(0), 32'd100);

        // Four channels scanned round-robin.
        per[0] = 50; per[1] = 80; per[2] = 120; per[3] = 200;
        do_reset(4'b1111);
        for (int k = 0; k < 5; k++) begin
            int ch;
            logic [31:0] exp_val;
            ch = k % 4;
            case (ch)
                0: exp_val = 32'd50;
                1: exp_val = 32'd80;
                2: exp_val = 32'd120;
                default: exp_val = 32'd200;
            endcase
            wait_update("scan_wait", 3000, cyc);
            check("scan_upd", 32'(update), 32'(4'b0001 << ch));
            check("scan_cur_ch", 32'(cur_ch), 32'(ch));
            check("scan_val", slice(ch), exp_val);
        end

        // Drop ch1 mid-measurement: no write, moves straight to ch2.
        wait_measure("abort_sync", 4'd1);
        @(negedge clk);
        enable_mask = 4'b1101;
        @(posedge clk); #1;
        check("abort_cur_ch", 32'(cur_ch), 32'd2);
        check("abort_update", 32'(update), 32'd0);
        check("abort_busy", 32'(busy), 32'd1);
        wait_update("abort_next", 3000, cyc);
        check("abort_next_upd", 32'(update), 32'b0100);
        check("abort_ch1_kept", slice(1), 32'd80);
        check("abort_ch2_val", slice(2), 32'd120);

        // Asynchronous reset mid-measurement, then a fresh scan from ch0.
        wait_measure("rst_sync", 4'd3);
        @(negedge clk); #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_freq", 32'(frequency != 128'd0), 32'd0);
        check("mid_rst_update", 32'(update), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_cur_ch", 32'(cur_ch), 32'd0);
        enable_mask = 4'b1111;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("fresh_cur_ch", 32'(cur_ch), 32'd0);
        check("fresh_busy", 32'(busy), 32'd1);
        wait_update("fresh_store", 3000, cyc);
        check("fresh_upd", 32'(update), 32'b0001);
        check("fresh_val", slice(0), 32'd50);
        check("fresh_ch1_cleared", slice(1), 32'd0);

        // Channel held low: timeout stores 0, 1004 cycles per round.
        per[0] = 0; per[1] = 0; per[2] = 0; per[3] = 0;
        do_reset(4'b0000);
        @(negedge clk);
        enable_mask = 4'b0100;
        wait_update("timeout_first", 1500, cyc);
        check("timeout_first_lat", 32'(cyc), 32'd1004);
        check("timeout_upd", 32'(update), 32'b0100);
        check("timeout_val", slice(2), 32'd0);
        wait_update("timeout_second", 1500, cyc);
        check("timeout_interval", 32'(cyc), 32'd1004);
        check("timeout_upd2", 32'(update), 32'b0100);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
